ip_full_driver: RTL and testbench
=================================

Name: ip_full_driver

Overview:
- Initiator-side driver for the ip_full data interface (din_a/din_b in; dout_a/dout_b/ready out).
- Accepts operand requests over a valid/ready port and drives din_a/din_b as registered, stable values.
- Waits a fixed settle time, then polls ip ready with a timeout, captures dout_a/dout_b, and returns a response over a valid/ready port.
- Sits between a sequencer/CPU-side master and the ip_full instance; it is the active counterpart of the passive top-level wrapper.

Parameters:
- A_W, 8, width of operand/result A (din_a/dout_a)
- B_W, 4, width of operand/result B (din_b/dout_b)
- SETTLE, 2, cycles din is held before ready is first sampled; legal range >=1
- TIMEOUT, 16, maximum WAIT cycles before error response; legal range >=1
- CNT_W, 16, width of saturating status counters

Ports:
- clk  input  1  sole clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  upstream request valid
- req_ready  output  1  driver can accept request
- req_a  input  A_W  operand A
- req_b  input  B_W  operand B
- ip_din_a  output  A_W  registered drive to ip din_a
- ip_din_b  output  B_W  registered drive to ip din_b
- ip_dout_a  input  A_W  ip result A
- ip_dout_b  input  B_W  ip result B
- ip_ready  input  1  ip result-valid indication
- rsp_valid  output  1  response valid
- rsp_ready  input  1  downstream accepts response
- rsp_a  output  A_W  captured dout_a (0 on error)
- rsp_b  output  B_W  captured dout_b (0 on error)
- rsp_err  output  1  1 = timeout, no ready seen
- txn_cnt  output  CNT_W  completed responses, saturating
- err_cnt  output  CNT_W  timeout responses, saturating

Behaviour:
- Reset (async assert, sync deassert by design): state IDLE, cnt 0.
- Outputs at reset: req_ready 1, rsp_valid 0, all other outputs 0.
- States: IDLE, DRIVE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: ip_din_a<=req_a, ip_din_b<=req_b, cnt<=0, go DRIVE.
- DRIVE:
  - req_ready=0.
  - cnt increments each cycle.
  - At cnt==SETTLE-1: cnt<=0, go WAIT.
  - ip_ready is ignored in DRIVE (stale result from a prior op).
- WAIT:
  - If ip_ready==1: rsp_a<=ip_dout_a, rsp_b<=ip_dout_b, rsp_err<=0, go RESP.
  - Else if cnt==TIMEOUT-1: rsp_a<=0, rsp_b<=0, rsp_err<=1, go RESP.
  - Else cnt++.
  - If ip_ready and the timeout coincide, ready wins (no error).
- RESP:
  - rsp_valid=1; rsp_* stable until handshake.
  - On rsp_valid&&rsp_ready: go IDLE; txn_cnt++ (sat); err_cnt++ if rsp_err (sat).
  - Backpressure is unbounded; no timeout applies in RESP.
- No bypass: req_ready is 0 in DRIVE/WAIT/RESP. A new request is accepted at the earliest on the cycle after the response handshake.
- Latency:
  - Acceptance edge = E0.
  - rsp_valid rises after edge E(SETTLE+1) when ip_ready is high at the first WAIT sample.
  - Timeout path: rsp_valid rises after edge E(SETTLE+TIMEOUT).
- ip_din_a/b hold the last driven value after completion. They change only at request acceptance.
- Counters saturate at all-ones and never wrap.
- Reset mid-operation: immediate return to reset values. The in-flight request is dropped, with no response.
- Inputs are sampled only in the states listed; X on unused inputs must not propagate.

Decomposition:
- Package ip_full_pkg:
  - A_W/B_W default constants.
  - State enum {IDLE, DRIVE, WAIT, RESP} as a 2-bit typedef.
  - Response struct {a, b, err}.
- One natural sub-module: ip_full_sat_cnt (parameterised saturating counter with enable), instantiated twice for txn_cnt/err_cnt.
- The FSM and settle/timeout counter stay in ip_full_driver.

Test Plan:
- Reset: rst_n=0 mid-WAIT -> same cycle rsp_valid=0, req_ready=1, ip_din_a=0x00, ip_din_b=0x0, counters 0.
- Basic: req_a=0xA5, req_b=0x3, ip_ready tied 1, dout=0x5A/0xC, rsp_ready=1 -> ip_din=0xA5/0x3 after E0; rsp_valid after E3 (SETTLE=2); rsp_a=0x5A, rsp_b=0xC, rsp_err=0; txn_cnt=1.
- Delayed ready: ip_ready rises on the 5th WAIT cycle -> rsp_valid after E7; no error; req_ready=0 throughout DRIVE/WAIT.
- Timeout: ip_ready=0 -> rsp_valid after E18 (2+16); rsp_err=1; rsp_a=0, rsp_b=0; err_cnt=1. Repeat with ready rising exactly on the final WAIT cycle -> rsp_err=0.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0; a req_valid presented meanwhile is not accepted until the cycle after the handshake.
- Saturation (CNT_W=2): 5 back-to-back transactions -> txn_cnt sticks at 3.

Source files
------------

// File: rtl/ip_full_pkg.sv
// Shared types and defaults for the ip_full initiator-side driver.
package ip_full_pkg;

  localparam int A_W_DEF = 8;
  localparam int B_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [A_W_DEF-1:0] a;
    logic [B_W_DEF-1:0] b;
    logic               err;
  } rsp_t;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/ip_full_sat_cnt.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module ip_full_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ip_full_driver.sv
// Initiator-side driver for ip_full: drives din, waits a settle time, polls
// ready with a timeout and returns the captured result over valid/ready.
module ip_full_driver
  import ip_full_pkg::*;
#(
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [A_W-1:0]   req_a,
  input  logic [B_W-1:0]   req_b,
  output logic [A_W-1:0]   ip_din_a,
  output logic [B_W-1:0]   ip_din_b,
  input  logic [A_W-1:0]   ip_dout_a,
  input  logic [B_W-1:0]   ip_dout_b,
  input  logic             ip_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [A_W-1:0]   rsp_a,
  output logic [B_W-1:0]   rsp_b,
  output logic             rsp_err,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // One counter serves both the settle phase and the ready-poll window.
  localparam int TW = $clog2(max_int(SETTLE, TIMEOUT) + 1);

  state_e        state;
  logic [TW-1:0] cnt;
  logic          rsp_hs;

  // NOTE: all state updates use <= so every register samples pre-edge values,
  // independent of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      ip_din_a  <= '0;
      ip_din_b  <= '0;
      rsp_valid <= 1'b0;
      rsp_a     <= '0;
      rsp_b     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ip_din_a  <= req_a;
            ip_din_b  <= req_b;
            cnt       <= '0;
            req_ready <= 1'b0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          // ip_ready may still reflect the previous operation here.
          if (cnt == TW'(SETTLE - 1)) begin
            cnt   <= '0;
            state <= WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (ip_ready) begin
            rsp_a     <= ip_dout_a;
            rsp_b     <= ip_dout_b;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            rsp_a     <= '0;
            rsp_b     <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gate on state first so an unknown rsp_ready outside RESP cannot leak.
  assign rsp_hs = (state == RESP) && rsp_ready;

  ip_full_sat_cnt #(.W(CNT_W)) u_txn_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rsp_hs),
    .cnt   (txn_cnt)
  );

  ip_full_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rsp_hs && rsp_err),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_ip_full_driver.sv
// Scoreboard bench for ip_full_driver: randomized requests and ip timing,
// checked against a transaction-level model of the driver's contract.
module tb_ip_full_driver;
  import ip_full_pkg::*;

  localparam int A_W     = 8;
  localparam int B_W     = 4;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [A_W-1:0]   req_a;
  logic [B_W-1:0]   req_b;
  logic [A_W-1:0]   ip_din_a;
  logic [B_W-1:0]   ip_din_b;
  logic [A_W-1:0]   ip_dout_a;
  logic [B_W-1:0]   ip_dout_b;
  logic             ip_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [A_W-1:0]   rsp_a;
  logic [B_W-1:0]   rsp_b;
  logic             rsp_err;
  logic [CNT_W-1:0] txn_cnt;
  logic [CNT_W-1:0] err_cnt;

  ip_full_driver #(
    .A_W(A_W), .B_W(B_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .ip_din_a(ip_din_a), .ip_din_b(ip_din_b),
    .ip_dout_a(ip_dout_a), .ip_dout_b(ip_dout_b), .ip_ready(ip_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_err(rsp_err),
    .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    rsp_t r;
    int   rise;   // edge after which rsp_valid must be high
  } exp_t;

  exp_t           exp_q[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  bit             ready_model = 1'b1;
  logic [A_W-1:0] din_a_model = '0;
  logic [B_W-1:0] din_b_model = '0;
  int             txn_model = 0;
  int             err_model = 0;
  int             cur_k = 1;
  logic [A_W-1:0] cur_dout_a = '0;
  logic [B_W-1:0] cur_dout_b = '0;
  int             bp_force = 0;
  bit             rsp_rand_en = 1'b0;
  bit             abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: acceptance when idle, response after SETTLE plus the
  // ready delay (capped at TIMEOUT), error when ready never comes in time.
  always @(posedge clk) begin
    if (rst_n) begin : model
      bit   ev;
      int   kk;
      exp_t e;
      ev = (exp_q.size() > 0) && (cyc >= exp_q[0].rise);
      cyc = cyc + 1;
      if (req_valid && ready_model) begin
        ready_model = 1'b0;
        din_a_model = req_a;
        din_b_model = req_b;
        kk          = (cur_k > TIMEOUT) ? TIMEOUT : cur_k;
        e.r.err     = (cur_k > TIMEOUT);
        e.r.a       = e.r.err ? '0 : cur_dout_a;
        e.r.b       = e.r.err ? '0 : cur_dout_b;
        e.rise      = cyc + SETTLE + kk;
        exp_q.push_back(e);
      end
      if (ev && rsp_ready) begin
        e = exp_q.pop_front();
        if (txn_model < CNT_MAX) txn_model++;
        if (e.r.err && err_model < CNT_MAX) err_model++;
        ready_model = 1'b1;
      end
    end
  end

  // Monitor: compare every visible output against the model each cycle.
  always @(negedge clk) begin
    if (rst_n) begin : mon
      bit ev;
      ev = (exp_q.size() > 0) && (cyc >= exp_q[0].rise);
      check("req_ready", 32'(req_ready), 32'(ready_model));
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev && rsp_valid) begin
        check("rsp_a", 32'(rsp_a), 32'(exp_q[0].r.a));
        check("rsp_b", 32'(rsp_b), 32'(exp_q[0].r.b));
        check("rsp_err", 32'(rsp_err), 32'(exp_q[0].r.err));
      end
      check("ip_din_a", 32'(ip_din_a), 32'(din_a_model));
      check("ip_din_b", 32'(ip_din_b), 32'(din_b_model));
      check("txn_cnt", 32'(txn_cnt), 32'(txn_model));
      check("err_cnt", 32'(err_cnt), 32'(err_model));
    end
  end

  always @(negedge clk) begin
    if (bp_force > 0) begin
      rsp_ready = 1'b0;
      bp_force  = bp_force - 1;
    end else begin
      rsp_ready = rsp_rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Issue one request; ip_ready first rises on WAIT cycle k (k > TIMEOUT
  // means never). stop_j > 0 abandons the ip side after that many edges.
  task automatic issue(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input int k,
                       input logic [A_W-1:0] da, input logic [B_W-1:0] db,
                       input int stop_j, input int bp);
    int n;
    int last;
    @(negedge clk);
    req_valid  = 1'b1;
    req_a      = a;
    req_b      = b;
    cur_k      = k;
    cur_dout_a = da;
    cur_dout_b = db;
    n = 0;
    while (!ready_model && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready_model) begin
      check("accept_bound", 32'(ready_model), 32'(1));
      abort     = 1'b1;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    last = (stop_j > 0) ? stop_j : SETTLE + ((k > TIMEOUT) ? TIMEOUT : k);
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      if (j == 1) begin
        req_valid = 1'b0;
        req_a     = A_W'($urandom);
        req_b     = B_W'($urandom);
      end
      if (j <= SETTLE) begin
        ip_ready  = 1'($urandom);
        ip_dout_a = A_W'($urandom);
        ip_dout_b = B_W'($urandom);
      end else begin
        ip_ready  = ((j - SETTLE) >= k);
        ip_dout_a = da;
        ip_dout_b = db;
      end
      @(posedge clk);
    end
    if (bp > 0) bp_force = bp;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    ip_ready  = 1'b0;
    ip_dout_a = '0;
    ip_dout_b = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'(1));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_ip_din_a", 32'(ip_din_a), 32'(0));
    check("rst_txn_cnt", 32'(txn_cnt), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'hA5, 4'h3, 1, 8'h5A, 4'hC, 0, 0);

    // Abandon a request mid-WAIT with a reset; no response may appear.
    issue(8'h11, 4'h2, TIMEOUT + 1, 8'h00, 4'h0, SETTLE + 3, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("midrst_req_ready", 32'(req_ready), 32'(1));
    check("midrst_ip_din_a", 32'(ip_din_a), 32'(0));
    check("midrst_ip_din_b", 32'(ip_din_b), 32'(0));
    check("midrst_txn_cnt", 32'(txn_cnt), 32'(0));
    check("midrst_err_cnt", 32'(err_cnt), 32'(0));
    exp_q.delete();
    ready_model = 1'b1;
    din_a_model = '0;
    din_b_model = '0;
    txn_model   = 0;
    err_model   = 0;
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'hC3, 4'h9, 5, 8'h81, 4'h6, 0, 0);
    issue(8'h0F, 4'hF, TIMEOUT + 1, 8'hEE, 4'hE, 0, 0);
    issue(8'hF0, 4'h1, TIMEOUT, 8'h42, 4'h7, 0, 10);
    issue(8'h77, 4'h5, 2, 8'h99, 4'hA, 0, 0);

    rsp_rand_en = 1'b1;
    for (int i = 0; i < 40 && !abort; i++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(A_W'($urandom), B_W'($urandom), $urandom_range(1, TIMEOUT + 3),
            A_W'($urandom), B_W'($urandom), 0, ($urandom_range(0, 7) == 0) ? 6 : 0);
    end
    rsp_rand_en = 1'b0;

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
    @(negedge clk);
    #1;
    check("txn_cnt_saturated", 32'(txn_cnt), 32'(CNT_MAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
